// File: rtl/mux_arb_n.sv
// mux_arb_n
// N-channel, W-bit arbitrating multiplexer with a one-entry registered output.
// Channel selection comes from a round-robin (mode=0) or fixed lowest-index
// priority (mode=1) arbiter. The chosen word is captured in the output
// register. That register accepts a new word whenever it is empty or is being
// drained on the same edge.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   mode       0 = round-robin, 1 = fixed priority
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (one-hot or zero)
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer takes the word this cycle
module mux_arb_n #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_sel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SELW-1:0]     ptr_q, ptr_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0]     out_sel_q, out_sel_d;
   logic                out_valid_q, out_valid_d;

   logic [CHANNELS-1:0] grant;
   logic                found;
   logic [SELW-1:0]     gnt_sel;
   logic [WIDTH-1:0]    gnt_data;
   logic                can_load;
   logic                accept;

   assign can_load = !out_valid_q || out_ready;

   // Two passes give the wrapped round-robin scan: first the channels at or
   // above ptr, then the ones below it. In fixed-priority mode the first pass
   // already covers every channel from index 0 upwards.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && in_valid[i] && (mode || (i >= int'(ptr_q)))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && !mode && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_sel  = '0;
      gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant[i]) begin
            gnt_sel  = SELW'(i);
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = grant & {CHANNELS{can_load}};
   assign accept   = found && can_load;

   always_comb begin
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_data_d  = gnt_data;
         out_sel_d   = gnt_sel;
         out_valid_d = 1'b1;
         if (!mode) begin
            // explicit wrap so non-power-of-two channel counts return to 0
            ptr_d = (gnt_sel == SELW'(CHANNELS - 1)) ? '0 : gnt_sel + SELW'(1);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Testbench for mux_arb_n: a 4-channel and a 3-channel instance share one
// stimulus stream (the 3-channel one sees the low three channels).
module tb_mux_arb_n;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mode;
   logic           out_ready;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_valid;

   logic [3:0]     rdy4;
   logic [2:0]     rdy3;
   logic [W-1:0]   od4, od3;
   logic [1:0]     os4, os3;
   logic           ov4, ov3;

   always #5 clk = ~clk;

   mux_arb_n #(.WIDTH(W), .CHANNELS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
      .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(out_ready)
   );

   mux_arb_n #(.WIDTH(W), .CHANNELS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
      .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(out_ready)
   );

   int checks = 0;
   int errors = 0;

   // reference model state per instance
   int          ptr_m [2];
   logic        ovm   [2];
   logic [33:0] sb0 [$];
   logic [33:0] sb1 [$];

   // Model: scan channels (ptr+k) mod n for round-robin, k for priority.
   task automatic model_inst(input int m, input int n, input logic [3:0] act_rdy);
      logic [3:0]  exp;
      logic [33:0] e;
      logic        cl;
      int          g;
      cl = !ovm[m] || out_ready;
      g  = -1;
      if (cl) begin
         for (int k = 0; k < n; k++) begin
            int idx;
            idx = mode ? k : (ptr_m[m] + k) % n;
            if (g < 0 && ((in_valid >> idx) & 4'd1) != 4'd0) g = idx;
         end
      end
      exp = (g >= 0) ? (4'd1 << g) : 4'd0;
      if (rst_n) begin
         checks++;
         if (act_rdy !== exp) begin
            errors++;
            $display("FAIL in_ready inst%0d got %b want %b", m, act_rdy, exp);
         end
      end
      if (!rst_n) begin
         ptr_m[m] = 0;
         ovm[m]   = 1'b0;
      end else if (g >= 0) begin
         e = {2'(g), in_data[g*W +: W]};
         if (m == 0) sb0.push_back(e);
         else        sb1.push_back(e);
         ovm[m] = 1'b1;
         if (!mode) ptr_m[m] = (g + 1) % n;
      end else if (out_ready) begin
         ovm[m] = 1'b0;
      end
   endtask

   task automatic step();
      #1;
      model_inst(0, 4, rdy4);
      model_inst(1, 3, {1'b0, rdy3});
      @(posedge clk);
      #1;
   endtask

   // monitor
   logic        armed    = 1'b0;
   logic        rst_prev = 1'b1;
   logic        clp [2];
   logic [33:0] last [2];

   task automatic mon(input int m, input logic v, input logic [W-1:0] d, input logic [1:0] s);
      logic [33:0] e;
      if (!rst_prev) begin
         checks++;
         if (v !== 1'b0 || d !== '0 || s !== 2'd0) begin
            errors++;
            $display("FAIL reset_state inst%0d got v=%b sel=%0d data=%h want 0/0/0", m, v, s, d);
         end
      end else if (v === 1'b1 && clp[m]) begin
         checks++;
         if ((m == 0 && sb0.size() == 0) || (m == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_word inst%0d got sel=%0d data=%h want none", m, s, d);
         end else begin
            if (m == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            last[m] = e;
            if ({s, d} !== e) begin
               errors++;
               $display("FAIL out_word inst%0d got sel=%0d data=%h want sel=%0d data=%h",
                        m, s, d, e[33:32], e[31:0]);
            end
         end
      end else if (!clp[m]) begin
         checks++;
         if (v !== 1'b1 || {s, d} !== last[m]) begin
            errors++;
            $display("FAIL hold inst%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     m, v, s, d, last[m][33:32], last[m][31:0]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         mon(0, ov4, od4, os4);
         mon(1, ov3, od3, os3);
      end
      armed    = 1'b1;
      rst_prev = rst_n;
      clp[0]   = !ov4 || out_ready;
      clp[1]   = !ov3 || out_ready;
   end

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      in_data   = {32'h40, 32'h30, 32'h20, 32'h10};
      ptr_m[0] = 0; ptr_m[1] = 0;
      ovm[0] = 1'b0; ovm[1] = 1'b0;
      @(posedge clk);
      #1;
      // reset with everything requesting
      step(); step();
      // round-robin rotation
      rst_n = 1'b1;
      repeat (5) step();
      // fixed priority with channels 1 and 3
      mode = 1'b1; in_valid = 4'b1010;
      repeat (3) step();
      // backpressure: load channel 2, stall, then drain + reload on one edge
      mode = 1'b0; in_valid = 4'b0100;
      in_data[2*W +: W] = 32'hDEADBEEF;
      step();
      out_ready = 1'b0; in_valid = 4'hF;
      repeat (3) step();
      out_ready = 1'b1; in_valid = 4'b1000;
      step();
      // wrap: highest channel of each instance alone, then all
      in_valid = 4'b0100; step();
      in_valid = 4'hF;    step();
      // reset mid-stream while channel 1 is being granted
      in_valid = 4'b0010; rst_n = 1'b0; step();
      rst_n = 1'b1; in_valid = 4'b0110;
      step(); step();
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = 4'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         step();
      end
      // drain
      rst_n = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
      repeat (3) step();
      #10;
      checks++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         errors++;
         $display("FAIL leftover_words got %0d/%0d want 0/0", sb0.size(), sb1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
